// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types and constants for the write-channel scheduler.
//   WR_CMD_DELAY_* : grant-to-first-occupancy delay per write source
//   DS_N           : beats a grant occupies its channel
//   src_id_e       : write source index (W, E, S, N, LF)
//   wr_sched_gnt_t : registered grant record (source, channel, command)
package vector_cache_pkg;

  localparam int DS_N = 4;

  localparam int WR_CMD_DELAY_W  = 2;
  localparam int WR_CMD_DELAY_E  = 3;
  localparam int WR_CMD_DELAY_S  = 5;
  localparam int WR_CMD_DELAY_N  = 4;
  localparam int WR_CMD_DELAY_LF = 6;

  localparam int WR_SCHED_CHANNEL = 8;
  localparam int WR_SCHED_REQ_NUM = 5;

  function automatic int wr_sched_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int WR_SCHED_MAX_DLY = wr_sched_max(
    wr_sched_max(wr_sched_max(WR_CMD_DELAY_W, WR_CMD_DELAY_E),
                 wr_sched_max(WR_CMD_DELAY_S, WR_CMD_DELAY_N)),
    WR_CMD_DELAY_LF);

  // Deep enough to hold the furthest window any grant can reserve.
  localparam int WR_SCHED_HORIZON = WR_SCHED_MAX_DLY + DS_N;

  typedef enum logic [2:0] {
    SRC_W  = 3'd0,
    SRC_E  = 3'd1,
    SRC_S  = 3'd2,
    SRC_N  = 3'd3,
    SRC_LF = 3'd4
  } src_id_e;

  typedef struct packed {
    logic [7:0]  addr;
    logic [3:0]  wmask;
    logic [31:0] data;
  } write_ram_cmd_t;

  typedef struct packed {
    src_id_e        src;
    logic [2:0]     ch;
    write_ram_cmd_t cmd;
  } wr_sched_gnt_t;

  function automatic int wr_sched_dly(input int src);
    case (src)
      0:       return WR_CMD_DELAY_W;
      1:       return WR_CMD_DELAY_E;
      2:       return WR_CMD_DELAY_S;
      3:       return WR_CMD_DELAY_N;
      default: return WR_CMD_DELAY_LF;
    endcase
  endfunction

endpackage

// File: rtl/vec_cache_wr_channel_sched_if.sv
// Bundle between the per-direction write arbiters (master) and the
// write-channel scheduler (slave).
//   req_vld_i/req_ch_i/req_pld_i : per-source request, held until req_rdy_o
//   req_rdy_o                    : one-hot (or zero) grant
//   gnt_*_o                      : registered grant record, one cycle after rdy
//   ch_busy_o                    : per-channel occupancy this cycle
//   res_err_o                    : sticky reservation-overlap flag
interface vec_cache_wr_channel_sched_if;
  import vector_cache_pkg::*;

  logic [WR_SCHED_REQ_NUM-1:0]        req_vld_i;
  logic [WR_SCHED_REQ_NUM-1:0]        req_rdy_o;
  logic [WR_SCHED_REQ_NUM-1:0][2:0]   req_ch_i;
  write_ram_cmd_t [WR_SCHED_REQ_NUM-1:0] req_pld_i;
  logic                               gnt_vld_o;
  logic [2:0]                         gnt_src_o;
  logic [2:0]                         gnt_ch_o;
  write_ram_cmd_t                     gnt_pld_o;
  logic [WR_SCHED_CHANNEL-1:0]        ch_busy_o;
  logic                               res_err_o;

  modport master (
    output req_vld_i, req_ch_i, req_pld_i,
    input  req_rdy_o, gnt_vld_o, gnt_src_o, gnt_ch_o, gnt_pld_o,
           ch_busy_o, res_err_o
  );

  modport slave (
    input  req_vld_i, req_ch_i, req_pld_i,
    output req_rdy_o, gnt_vld_o, gnt_src_o, gnt_ch_o, gnt_pld_o,
           ch_busy_o, res_err_o
  );
endinterface

// File: rtl/vec_cache_wr_channel_sched_rr_arb.sv
// Round-robin picker over N requesters.
//   clk, rst : clock, async active-high reset (pointer returns to 0)
//   req_i    : requesters competing this cycle
//   upd_i    : advance the pointer past the current winner
//   gnt_o    : one-hot winner, idx_o its index, any_o set when a winner exists
module vec_cache_rr_arb #(
  parameter  int N  = 5,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          upd_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] ptr_q, ptr_d;

  // Scan starting at the pointer; modulo done by a single subtract since
  // ptr + i never exceeds 2N-2.
  always_comb begin
    int r;
    logic [IW-1:0] ri;
    r     = 0;
    ri    = '0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      r = int'(ptr_q) + i;
      if (r >= N) r = r - N;
      ri = IW'(r);
      if (!any_o && req_i[ri]) begin
        any_o     = 1'b1;
        gnt_o[ri] = 1'b1;
        idx_o     = ri;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i && any_o) ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vec_cache_wr_channel_sched.sv
// Write-channel scheduler for the vector-cache SRAM groups.
// Keeps a per-channel reservation timeline res[c][k] (channel c busy at
// now+k), grants at most one source per cycle round-robin among sources
// whose future occupancy window is free, and reports current occupancy.
//   clk, rst : clock, async active-high reset
//   bus      : request/grant/status bundle (slave side)
module vec_cache_wr_channel_sched
  import vector_cache_pkg::*;
(
  input  logic clk,
  input  logic rst,
  vec_cache_wr_channel_sched_if.slave bus
);

  localparam int CHANNEL = WR_SCHED_CHANNEL;
  localparam int REQ_NUM = WR_SCHED_REQ_NUM;
  localparam int HORIZON = WR_SCHED_HORIZON;
  localparam int OCC_CYC = DS_N;

  logic [CHANNEL-1:0][HORIZON-1:0] res_q, res_d;
  logic          res_err_q, res_err_d;
  logic          gnt_vld_q, gnt_vld_d;
  wr_sched_gnt_t gnt_q, gnt_d;

  logic [REQ_NUM-1:0] elig;
  logic [REQ_NUM-1:0] win_oh;
  logic [2:0]         win_idx;
  logic               win_any;
  logic [2:0]         win_ch;
  int                 win_dly;

  // A source is eligible only if its whole window on its target channel is
  // free. rst masks requests so rdy stays low while the block is in reset.
  always_comb begin
    for (int r = 0; r < REQ_NUM; r++) begin
      elig[r] = bus.req_vld_i[r] & ~rst;
      for (int k = 0; k < HORIZON; k++) begin
        if (k >= wr_sched_dly(r) && k < wr_sched_dly(r) + OCC_CYC &&
            res_q[bus.req_ch_i[r]][k])
          elig[r] = 1'b0;
      end
    end
  end

  vec_cache_rr_arb #(.N(REQ_NUM)) u_rr_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (elig),
    .upd_i (win_any),
    .gnt_o (win_oh),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  assign win_ch  = bus.req_ch_i[win_idx];
  assign win_dly = wr_sched_dly(int'(win_idx));

  // Timeline advances one slot per cycle. The new window is marked one slot
  // earlier than its delay because the table has already shifted by the
  // time it is read again.
  always_comb begin
    res_err_d = res_err_q;
    for (int c = 0; c < CHANNEL; c++) res_d[c] = {1'b0, res_q[c][HORIZON-1:1]};
    if (win_any) begin
      for (int k = 0; k < HORIZON; k++) begin
        if (k >= win_dly - 1 && k <= win_dly + OCC_CYC - 2) begin
          if (res_d[win_ch][k]) res_err_d = 1'b1;
          res_d[win_ch][k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_vld_d = win_any;
    gnt_d     = gnt_q;
    if (win_any) begin
      gnt_d.src = src_id_e'(win_idx);
      gnt_d.ch  = win_ch;
      gnt_d.cmd = bus.req_pld_i[win_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q     <= '0;
      res_err_q <= 1'b0;
      gnt_vld_q <= 1'b0;
      gnt_q     <= '0;
    end else begin
      res_q     <= res_d;
      res_err_q <= res_err_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_q     <= gnt_d;
    end
  end

  assign bus.req_rdy_o = win_oh;
  assign bus.gnt_vld_o = gnt_vld_q;
  assign bus.gnt_src_o = gnt_q.src;
  assign bus.gnt_ch_o  = gnt_q.ch;
  assign bus.gnt_pld_o = gnt_q.cmd;
  assign bus.res_err_o = res_err_q;

  always_comb begin
    for (int c = 0; c < CHANNEL; c++) bus.ch_busy_o[c] = res_q[c][0];
  end

endmodule

// File: tb/tb_vec_cache_wr_channel_sched.sv
// Bench for the write-channel scheduler: a directed vector table, hand-written
// corner sequences, then random traffic against an absolute-time occupancy model.
module tb_vec_cache_wr_channel_sched;
  import vector_cache_pkg::*;

  localparam int NR         = WR_SCHED_REQ_NUM;
  localparam int NC         = WR_SCHED_CHANNEL;
  localparam int RING       = 32;
  localparam int RAND_CYC   = 10000;
  localparam int STARVE_MAX = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  vec_cache_wr_channel_sched_if bus ();
  vec_cache_wr_channel_sched dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [NR-1:0]      vld;
    logic [NR-1:0][2:0] ch;
    logic [NR-1:0]      rdy;
    logic [NC-1:0]      busy;
  } vec_t;

  // Grant-to-occupancy delay per source W, E, S, N, LF.
  int dly_tab [NR] = '{2, 3, 5, 4, 6};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic write_ram_cmd_t mk_pld(input int seed);
    logic [63:0] t;
    t = {32'(seed) * 32'h9e37_79b9, 32'(seed) ^ 32'h5a5a_0f0f};
    return t[$bits(write_ram_cmd_t)-1:0];
  endfunction

  function automatic vec_t mkv(input logic [4:0] vld, input logic [2:0] c0, input logic [2:0] c1,
                               input logic [2:0] c2, input logic [2:0] c3, input logic [2:0] c4,
                               input logic [4:0] rdy, input logic [7:0] busy);
    vec_t v;
    v.vld  = vld;
    v.ch   = {c4, c3, c2, c1, c0};
    v.rdy  = rdy;
    v.busy = busy;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req_vld_i = '0;
    bus.req_ch_i  = '0;
    bus.req_pld_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t tbl [12];
  int   mptr, w, ri, slot, max_wait, last_w;
  bit   free;
  bit   mres [NC][RING];
  bit   sb   [NC][RING];
  int   wait_c [NR];
  logic pv;
  logic [2:0] psrc, pch;
  write_ram_cmd_t ppld;
  logic [NR-1:0] exp_rdy;
  logic [NC-1:0] exp_busy;

  initial begin
    // ---------------- reset values (requests asserted, rdy must stay low)
    idle_inputs();
    @(negedge clk);
    bus.req_vld_i = '1;
    bus.req_ch_i  = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    #1;
    chk("rst_rdy",     bus.req_rdy_o, 0);
    chk("rst_busy",    bus.ch_busy_o, 0);
    chk("rst_gnt_vld", bus.gnt_vld_o, 0);
    chk("rst_gnt_src", bus.gnt_src_o, 0);
    chk("rst_gnt_ch",  bus.gnt_ch_o, 0);
    chk("rst_gnt_pld", bus.gnt_pld_o, 0);
    chk("rst_res_err", bus.res_err_o, 0);
    idle_inputs();
    tick();
    rst = 1'b0;

    // ---------------- vector table: rr order, window blocking, hole reuse
    tbl[0]  = mkv(5'b11111, 0, 1, 2, 3, 4, 5'b00001, 8'h00);
    tbl[1]  = mkv(5'b11111, 0, 1, 2, 3, 4, 5'b00010, 8'h00);
    tbl[2]  = mkv(5'b11111, 0, 1, 2, 3, 4, 5'b00100, 8'h01);
    tbl[3]  = mkv(5'b11111, 0, 1, 2, 3, 4, 5'b01000, 8'h01);
    tbl[4]  = mkv(5'b11111, 0, 1, 2, 3, 4, 5'b10000, 8'h03);
    tbl[5]  = mkv(5'b11111, 0, 1, 2, 3, 4, 5'b00001, 8'h03);
    tbl[6]  = mkv(5'b00010, 0, 0, 0, 0, 0, 5'b00000, 8'h02);
    tbl[7]  = mkv(5'b00010, 0, 0, 0, 0, 0, 5'b00000, 8'h0F);
    tbl[8]  = mkv(5'b00010, 0, 0, 0, 0, 0, 5'b00010, 8'h0D);
    tbl[9]  = mkv(5'b00001, 0, 0, 0, 0, 0, 5'b00000, 8'h0D);
    tbl[10] = mkv(5'b00001, 0, 0, 0, 0, 0, 5'b00000, 8'h1D);
    tbl[11] = mkv(5'b00000, 0, 0, 0, 0, 0, 5'b00000, 8'h11);
    for (int i = 0; i < 12; i++) begin
      bus.req_vld_i = tbl[i].vld;
      bus.req_ch_i  = tbl[i].ch;
      for (int r = 0; r < NR; r++) bus.req_pld_i[r] = mk_pld(i * 8 + r);
      #1;
      chk("tbl_rdy",  bus.req_rdy_o, tbl[i].rdy);
      chk("tbl_busy", bus.ch_busy_o, tbl[i].busy);
      if (i > 0) begin
        chk("tbl_gnt_vld", bus.gnt_vld_o, |tbl[i-1].rdy);
        for (int r = 0; r < NR; r++) begin
          if (tbl[i-1].rdy[r]) begin
            chk("tbl_gnt_src", bus.gnt_src_o, r);
            chk("tbl_gnt_ch",  bus.gnt_ch_o, tbl[i-1].ch[r]);
            chk("tbl_gnt_pld", bus.gnt_pld_o, mk_pld((i - 1) * 8 + r));
          end
        end
      end
      tick();
    end

    // ---------------- single W to ch3: busy exactly T+2..T+5
    do_reset();
    bus.req_vld_i[0] = 1'b1;
    bus.req_ch_i[0]  = 3'd3;
    bus.req_pld_i[0] = mk_pld(100);
    #1;
    chk("s1_rdy", bus.req_rdy_o, 5'b00001);
    tick();
    idle_inputs();
    for (int t = 1; t <= 7; t++) begin
      #1;
      chk("s1_busy", bus.ch_busy_o, (t >= 2 && t <= 5) ? 8'h08 : 8'h00);
      chk("s1_gnt_vld", bus.gnt_vld_o, (t == 1) ? 1'b1 : 1'b0);
      if (t == 1) begin
        chk("s1_gnt_src", bus.gnt_src_o, 0);
        chk("s1_gnt_ch",  bus.gnt_ch_o, 3);
        chk("s1_gnt_pld", bus.gnt_pld_o, mk_pld(100));
      end
      tick();
    end

    // ---------------- W at T, E at T+1 on ch5: E waits until T+3 (abutting)
    do_reset();
    for (int t = 0; t <= 10; t++) begin
      idle_inputs();
      if (t == 0) begin
        bus.req_vld_i[0] = 1'b1; bus.req_ch_i[0] = 3'd5; bus.req_pld_i[0] = mk_pld(200);
      end
      if (t >= 1 && t <= 3) begin
        bus.req_vld_i[1] = 1'b1; bus.req_ch_i[1] = 3'd5; bus.req_pld_i[1] = mk_pld(201);
      end
      #1;
      chk("s2_rdy", bus.req_rdy_o, (t == 0) ? 5'b00001 : (t == 3) ? 5'b00010 : 5'b00000);
      chk("s2_busy5", bus.ch_busy_o[5], (t >= 2 && t <= 9) ? 1'b1 : 1'b0);
      if (t == 4) begin
        chk("s2_gnt_src", bus.gnt_src_o, 1);
        chk("s2_gnt_ch",  bus.gnt_ch_o, 5);
        chk("s2_gnt_pld", bus.gnt_pld_o, mk_pld(201));
      end
      tick();
    end
    chk("s2_res_err", bus.res_err_o, 0);

    // ---------------- pointer at 4, LF and S to ch0: LF at T, S at T+5
    do_reset();
    for (int k = 0; k < 4; k++) begin
      idle_inputs();
      bus.req_vld_i[k] = 1'b1;
      bus.req_ch_i[k]  = 3'(k + 1);
      #1;
      chk("s4_setup_rdy", bus.req_rdy_o, 5'(1 << k));
      tick();
    end
    for (int t = 0; t <= 14; t++) begin
      idle_inputs();
      if (t == 0) begin
        bus.req_vld_i[4] = 1'b1; bus.req_ch_i[4] = 3'd0; bus.req_pld_i[4] = mk_pld(400);
      end
      if (t <= 5) begin
        bus.req_vld_i[2] = 1'b1; bus.req_ch_i[2] = 3'd0; bus.req_pld_i[2] = mk_pld(402);
      end
      #1;
      chk("s4_rdy", bus.req_rdy_o, (t == 0) ? 5'b10000 : (t == 5) ? 5'b00100 : 5'b00000);
      chk("s4_busy0", bus.ch_busy_o[0], (t >= 6 && t <= 13) ? 1'b1 : 1'b0);
      if (t == 1) chk("s4_gnt_src_lf", bus.gnt_src_o, 4);
      if (t == 6) chk("s4_gnt_src_s", bus.gnt_src_o, 2);
      tick();
    end

    // ---------------- reset while ch2 and ch7 are busy
    do_reset();
    for (int t = 0; t < 4; t++) begin
      idle_inputs();
      if (t == 0) begin bus.req_vld_i[0] = 1'b1; bus.req_ch_i[0] = 3'd2; end
      if (t == 1) begin bus.req_vld_i[1] = 1'b1; bus.req_ch_i[1] = 3'd7; end
      if (t == 3) begin bus.req_vld_i[3] = 1'b1; bus.req_ch_i[3] = 3'd6; end
      tick();
    end
    idle_inputs();
    bus.req_vld_i[0] = 1'b1;
    bus.req_ch_i[0]  = 3'd2;
    bus.req_pld_i[0] = mk_pld(500);
    #1;
    chk("s5_pre_busy",    bus.ch_busy_o, 8'h84);
    chk("s5_pre_gnt_vld", bus.gnt_vld_o, 1);
    chk("s5_pre_rdy",     bus.req_rdy_o, 5'b00001);
    rst = 1'b1;
    #1;
    chk("s5_rst_busy",    bus.ch_busy_o, 0);
    chk("s5_rst_gnt_vld", bus.gnt_vld_o, 0);
    chk("s5_rst_rdy",     bus.req_rdy_o, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("s5_post_rdy", bus.req_rdy_o, 5'b00001);
    tick();
    idle_inputs();
    #1;
    chk("s5_post_gnt_vld", bus.gnt_vld_o, 1);
    chk("s5_post_gnt_ch",  bus.gnt_ch_o, 2);

    // ---------------- random traffic against an absolute-time model
    do_reset();
    mptr = 0; pv = 1'b0; last_w = -1; max_wait = 0;
    psrc = '0; pch = '0; ppld = '0;
    for (int c = 0; c < NC; c++)
      for (int s = 0; s < RING; s++) begin mres[c][s] = 1'b0; sb[c][s] = 1'b0; end
    for (int r = 0; r < NR; r++) wait_c[r] = 0;

    for (int cyc = 0; cyc < RAND_CYC; cyc++) begin
      for (int r = 0; r < NR; r++) begin
        if (r == last_w || (!bus.req_vld_i[r] && $urandom_range(3, 0) == 0)) begin
          bus.req_vld_i[r] = (r == last_w) ? ($urandom_range(1, 0) == 1) : 1'b1;
          bus.req_ch_i[r]  = 3'($urandom_range(NC - 1, 0));
          bus.req_pld_i[r] = mk_pld($urandom);
        end
      end
      #1;

      w = -1;
      for (int i = 0; i < NR; i++) begin
        ri = (mptr + i) % NR;
        if (w < 0 && bus.req_vld_i[ri]) begin
          free = 1'b1;
          for (int j = 0; j < DS_N; j++)
            if (mres[bus.req_ch_i[ri]][(cyc + dly_tab[ri] + j) % RING]) free = 1'b0;
          if (free) w = ri;
        end
      end
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      for (int c = 0; c < NC; c++) exp_busy[c] = mres[c][cyc % RING];

      chk("rnd_rdy",     bus.req_rdy_o, exp_rdy);
      chk("rnd_busy",    bus.ch_busy_o, exp_busy);
      chk("rnd_gnt_vld", bus.gnt_vld_o, pv);
      chk("rnd_res_err", bus.res_err_o, 0);
      if (pv) begin
        chk("rnd_gnt_src", bus.gnt_src_o, psrc);
        chk("rnd_gnt_ch",  bus.gnt_ch_o, pch);
        chk("rnd_gnt_pld", bus.gnt_pld_o, ppld);
      end

      // Occupancy rebuilt purely from the DUT's grant record (grant was last cycle).
      if (bus.gnt_vld_o === 1'b1 && bus.gnt_src_o < 3'(NR)) begin
        for (int j = 0; j < DS_N; j++) begin
          slot = (cyc - 1 + dly_tab[bus.gnt_src_o] + j) % RING;
          chk("sb_overlap", sb[bus.gnt_ch_o][slot], 0);
          sb[bus.gnt_ch_o][slot] = 1'b1;
        end
      end

      pv = (w >= 0);
      if (w >= 0) begin
        psrc = 3'(w);
        pch  = bus.req_ch_i[w];
        ppld = bus.req_pld_i[w];
        for (int j = 0; j < DS_N; j++) mres[pch][(cyc + dly_tab[w] + j) % RING] = 1'b1;
        mptr = (w + 1) % NR;
      end
      for (int c = 0; c < NC; c++) begin
        mres[c][cyc % RING] = 1'b0;
        sb[c][cyc % RING]   = 1'b0;
      end

      for (int r = 0; r < NR; r++) begin
        if (r == w) wait_c[r] = 0;
        else if (bus.req_vld_i[r]) wait_c[r]++;
        if (wait_c[r] > max_wait) max_wait = wait_c[r];
      end
      last_w = w;
      tick();
    end
    chk("rnd_no_starvation", (max_wait < STARVE_MAX) ? 1'b1 : 1'b0, 1'b1);
    chk("rnd_res_err_end", bus.res_err_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vec_cache_wr_channel_sched.md
Name: vec_cache_wr_channel_sched

Overview:
Scheduler for the 8 write channels into the vector-cache SRAM groups. There are five write sources: west, east, south, north and linefill. Each source starts occupying its target channel a fixed number of cycles after grant (WR_CMD_DELAY_*), and holds it for DS_N beats. The block keeps a per-channel reservation timeline, grants at most one source per cycle round-robin among sources whose occupancy window is free, and exports the current per-channel occupancy. It sits between the per-direction write arbiters and the SRAM write datapath.

Parameters:
CHANNEL, 8, number of write channels
REQ_NUM, 5, number of sources; index 0=W, 1=E, 2=S, 3=N, 4=LF
OCC_CYC, 4 (DS_N), cycles a grant occupies its channel
DLY_W/E/S/N/LF, 2/3/5/4/6, grant-to-first-occupancy delay per source
HORIZON, max(DLY)+OCC_CYC = 10, reservation timeline depth

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_vld_i  in  REQ_NUM  per-source request valid
req_rdy_o  out  REQ_NUM  per-source grant (one-hot or zero); handshake = vld & rdy
req_ch_i  in  REQ_NUM*3  target channel per source
req_pld_i  in  REQ_NUM*$bits(write_ram_cmd_t)  per-source command payload
gnt_vld_o  out  1  registered grant pulse
gnt_src_o  out  3  granted source index
gnt_ch_o  out  3  granted channel
gnt_pld_o  out  $bits(write_ram_cmd_t)  granted payload
ch_busy_o  out  CHANNEL  channel occupied in the current cycle
res_err_o  out  1  sticky: overlap detected when marking (assertion aid)

Behaviour:
- Reset (async, rst=1): reservation table cleared; rr pointer=0; gnt_vld_o=0; gnt_src_o/gnt_ch_o/gnt_pld_o=0; ch_busy_o=0; res_err_o=0; req_rdy_o=0.
- Reservation table: res[c][k], c<CHANNEL, k<HORIZON. res[c][k]=1 means channel c is busy at cycle now+k. ch_busy_o[c]=res[c][0].
- Eligibility (combinational, cycle T): elig[r] = req_vld_i[r] & (res[req_ch_i[r]][DLY_r .. DLY_r+OCC_CYC-1] == 0).
- Arbitration: round-robin over elig starting at rr pointer. The winner w gets req_rdy_o[w]=1; all other rdy=0. If no source is eligible, all rdy=0. rdy depends on valid and must not be used by a source to form valid.
- On grant at T:
  - rr pointer becomes (w+1) mod REQ_NUM.
  - gnt_* registered at T+1 (latency 1) with payload, source and channel.
  - Channel is busy over cycles T+DLY_w .. T+DLY_w+OCC_CYC-1 (ch_busy_o high there).
- Update each cycle: res_next[c][k] = res[c][k+1] (with res[c][HORIZON]=0), OR-ed with the new mark at k = DLY_w-1 .. DLY_w+OCC_CYC-2 for c=gnt ch. If a marked bit was already 1, set res_err_o. This is unreachable by design.
- Non-granted requests hold: the source keeps vld and pld stable until rdy. Starvation bound: rr guarantees service once the source's window is free at its turn.
- Simultaneous same-channel requests with different delays: only one is granted per cycle; the other re-checks next cycle against the updated table.
- Back-to-back grants to the same channel are legal when windows abut, e.g. W at T then W at T+4.
- Holes in the table are reused by sources with a different delay when they fit.
- Reset mid-operation discards all reservations; outstanding occupancy is not tracked after reset.

Decomposition:
- Package (vector_cache_pkg): WR_CMD_DELAY_* constants (already present); add a src_id enum (W, E, S, N, LF), localparam WR_SCHED_HORIZON, and a wr_sched_gnt_t struct (src, ch, write_ram_cmd_t).
- Sub-module: vec_cache_rr_arb, a parameterised REQ_NUM round-robin picker with a pointer update input. The reservation timeline stays inline.

Test Plan:
- Single W request, ch=3, at T=10 -> rdy at 10; gnt_vld_o at 11 with src=0, ch=3; ch_busy_o[3]=1 for cycles 12-15 only.
- W (dly 2) at T and E (dly 3) at T+1, both ch=5 -> W granted T (busy T+2..T+5). E blocked until its window T'+3 ≥ T+6, i.e. granted at T+3; no overlap; res_err_o stays 0.
- All 5 sources valid on distinct channels, continuous -> grants in order 0,1,2,3,4,0, one per cycle; each source served exactly once per 5 cycles.
- LF (dly 6) and S (dly 5) both to ch=0 at T, pointer at 4 -> LF granted (busy T+6..T+9). S window T+5..T+8 conflicts, so S is granted at T+5 (busy T+10..T+13).
- Reset asserted while ch 2 and 7 are busy -> ch_busy_o, gnt_vld_o and rdy drop to 0 immediately. After release, a W request to ch 2 is granted on the first cycle.
- Random vld/ch traffic for 10k cycles with a scoreboard rebuilding occupancy from gnt_* -> no channel ever double-occupied; res_err_o=0; every request eventually granted.
